// File: rtl/vector_scale_pkg.sv
// Shared types and constants for the vector_scale_seq block.
// Holds the controller state encoding, operand/product widths and a helper
// that sizes the element index counter.
package vector_scale_pkg;

  localparam int ELEM_W = 8;
  localparam int PROD_W = 16;

  // Controller phases: wait for operands, walk the vector, present result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index counter width: enough bits to address SIZE elements, never zero.
  function automatic int idx_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/vector_scale_seq_mul8x8.sv
// mul8x8: combinational 8x8 -> 16-bit multiplier shared by all elements.
// Build option VECTOR_SCALE_SIGNED_EN selects two's complement operands;
// without it operands are unsigned. A 16-bit result holds the full product
// either way, so nothing is ever truncated or saturated.
module mul8x8
  import vector_scale_pkg::*;
(
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [PROD_W-1:0] p
);

`ifdef VECTOR_SCALE_SIGNED_EN
  logic signed [PROD_W-1:0] a_x;
  logic signed [PROD_W-1:0] b_x;
  logic signed [PROD_W-1:0] p_s;

  // Sign-extend both operands to the product width before multiplying.
  assign a_x = {{(PROD_W-ELEM_W){a[ELEM_W-1]}}, a};
  assign b_x = {{(PROD_W-ELEM_W){b[ELEM_W-1]}}, b};
  assign p_s = a_x * b_x;
  assign p   = p_s;
`else
  logic [PROD_W-1:0] a_x;
  logic [PROD_W-1:0] b_x;

  // Zero-extend both operands to the product width before multiplying.
  assign a_x = {{(PROD_W-ELEM_W){1'b0}}, a};
  assign b_x = {{(PROD_W-ELEM_W){1'b0}}, b};
  assign p   = a_x * b_x;
`endif

endmodule

// File: rtl/vector_scale_seq.sv
// vector_scale_seq: multiplies one scalar across a vector of SIZE elements,
// one element per cycle through a single shared mul8x8.
// Operands are captured on the input handshake, the products are written
// into a result register array during CALC, and the completed vector is held
// in DONE until the consumer takes it. in_ready and out_valid are flops fed
// from the next-state decode, so neither depends combinationally on inputs.
// Build option: VECTOR_SCALE_SIGNED_EN (signed operands in the multiplier).
module vector_scale_seq
  import vector_scale_pkg::*;
#(
  parameter int SIZE = 4
)
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ELEM_W-1:0]      scalar,
  input  logic [ELEM_W*SIZE-1:0] vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PROD_W*SIZE-1:0] out_vec
);

  localparam int IDX_W = idx_width(SIZE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE - 1);

  state_t            state_q;
  state_t            state_nxt;
  logic              in_ready_q;
  logic              in_ready_nxt;
  logic              out_valid_q;
  logic              out_valid_nxt;
  logic [IDX_W-1:0]  idx_q;
  logic              accept;
  logic              idx_last;

  logic [ELEM_W-1:0] scalar_q;
  logic [ELEM_W-1:0] vec_q  [SIZE];
  logic [PROD_W-1:0] prod_q [SIZE];
  logic [ELEM_W-1:0] elem;
  logic [PROD_W-1:0] prod;

  assign accept   = in_valid && (state_q == IDLE);
  assign idx_last = (idx_q == IDX_LAST);
  assign elem     = vec_q[idx_q];

  // Next state and the registered handshake outputs for that state.
  always_comb begin
    state_nxt     = state_q;
    in_ready_nxt  = 1'b0;
    out_valid_nxt = 1'b0;
    unique case (state_q)
      IDLE: if (in_valid)  state_nxt = CALC;
      CALC: if (idx_last)  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
    in_ready_nxt  = (state_nxt == IDLE);
    out_valid_nxt = (state_nxt == DONE);
  end

  // State and handshake flops; reset returns to an empty, ready block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      in_ready_q  <= in_ready_nxt;
      out_valid_q <= out_valid_nxt;
    end
  end

  // Element index: cleared on accept, advances each CALC cycle up to SIZE-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else if (accept) begin
      idx_q <= '0;
    end else if (state_q == CALC) begin
      idx_q <= idx_last ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Operand capture; later changes on scalar/vec cannot disturb a run.
  always_ff @(posedge clk) begin
    if (accept) begin
      scalar_q <= scalar;
      for (int i = 0; i < SIZE; i++) begin
        vec_q[i] <= vec[ELEM_W*i +: ELEM_W];
      end
    end
  end

  mul8x8 u_mul (
    .a (scalar_q),
    .b (elem),
    .p (prod)
  );

  // Result array: one product written per CALC cycle, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) begin
        prod_q[i] <= '0;
      end
    end else if (state_q == CALC) begin
      prod_q[idx_q] <= prod;
    end
  end

  for (genvar g = 0; g < SIZE; g++) begin : g_out
    assign out_vec[PROD_W*g +: PROD_W] = prod_q[g];
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/vector_scale_seq.md
# vector_scale_seq

Sequential scalar-by-vector multiplier: accepts one 8-bit scalar and a flattened vector of SIZE 8-bit elements, and returns the SIZE element-wise 16-bit products. It is the broadcast counterpart of the dot-product reduction: the reduction collapses a vector to one value, and this block expands one value across a vector. It uses a single shared multiplier, one element per cycle, with valid/ready handshakes on both sides. It sits between vector producers and the dot-product/accumulation datapath.

## Interface
- SIZE, 4, number of 8-bit elements per vector (>= 1)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  scalar/vec valid
- in_ready  output  1  block can accept an input
- scalar  input  8  multiplier operand
- vec  input  8*SIZE  element i at vec[8*i +: 8]
- out_valid  output  1  out_vec complete and stable
- out_ready  input  1  consumer accepts out_vec
- out_vec  output  16*SIZE  product i at out_vec[16*i +: 16]

## Operation
- FSM states:
  - IDLE: in_ready=1. Input handshake (in_valid && in_ready) latches scalar and vec, sets idx=0, and moves to CALC.
  - CALC: each cycle, out_vec[idx] <= scalar_q * vec_q[idx], then idx++. After the write with idx=SIZE-1, move to DONE.
  - DONE: out_valid=1. Output handshake (out_valid && out_ready) moves to IDLE.
- in_ready is high only in IDLE. Inputs are ignored in CALC and DONE.
- Latched operands are used throughout CALC. Changes on scalar/vec after acceptance have no effect.
- Arithmetic: 8x8 -> 16-bit full product, so no overflow or truncation is possible.
- out_vec is meaningful only while out_valid=1. During CALC it is partially updated. After the output handshake it keeps its value until overwritten by the next CALC.
- Backpressure: out_valid and out_vec stay constant while out_ready=0, for any number of cycles.
- idx width is $clog2(SIZE), minimum 1 bit. There is no wrap: CALC exits on idx==SIZE-1.
- Reset (any state, including mid-CALC): state=IDLE, idx=0, out_valid=0, in_ready=1, out_vec=0. A partial result is discarded and no output is produced.

## Timing
- Input accepted at clock edge T: CALC occupies edges T+1..T+SIZE, and out_valid=1 in the cycle after edge T+SIZE (latency SIZE cycles).
- Output handshake at edge U: in_ready=1 in the cycle after edge U. No same-cycle input accept in DONE.
- Throughput: one vector per SIZE+2 cycles with out_ready held high.
- SIZE=1: CALC lasts exactly one cycle.
- All outputs are registered. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- Macro: VECTOR_SCALE_SIGNED_EN.
  - Defined: scalar and elements are two's complement, and each product is a signed 16-bit value.
  - Undefined: operands are unsigned, and each product is an unsigned 16-bit value.
- The macro affects only the multiplier. The FSM and handshakes are identical in both builds.

## Structure
- Package vector_scale_pkg:
  - state enum (IDLE, CALC, DONE)
  - ELEM_W=8, PROD_W=16
- Sub-module mul8x8: combinational 8x8 multiplier honouring VECTOR_SCALE_SIGNED_EN, instantiated once.
- Top level holds the FSM, the idx counter, the operand registers and the out_vec register array.

## Test plan
- Basic: SIZE=4, scalar=3, vec elements [1,2,3,4] (i=0..3) -> out_vec elements [3,6,9,12]; out_valid rises exactly 4 cycles after the accept edge.
- Max unsigned (macro undefined): scalar=0xFF, all elements 0xFF -> every product 0xFE01.
- Signed (macro defined): scalar=0xFF (-1), elements [2,0x80,0,0x7F] -> [0xFFFE,0x0080,0x0000,0xFF81].
- Backpressure plus input hold-off:
  - Hold out_ready=0 for 10 cycles with in_valid=1 and new data -> out_vec unchanged, in_ready=0 throughout.
  - Raise out_ready -> in_ready=1 next cycle, then the new vector is accepted.
- Reset mid-CALC: assert rst after 2 CALC cycles -> next cycle out_valid=0, in_ready=1, out_vec=0. No out_valid pulse follows.
- Back-to-back with out_ready tied high: 3 vectors -> 3 results, each SIZE+2=6 cycles apart, values correct, none dropped.
